// File: rtl/ddot_feeder.sv
// ddot_feeder: gathers 16 streamed operand words for the 8-lane FP32 dot-product unit,
// starts it with a one-cycle ready pulse and returns its result over a valid/ready port.
module ddot_feeder #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      ddot_x0,
    output logic [31:0]      ddot_x1,
    output logic [31:0]      ddot_x2,
    output logic [31:0]      ddot_x3,
    output logic [31:0]      ddot_x4,
    output logic [31:0]      ddot_x5,
    output logic [31:0]      ddot_x6,
    output logic [31:0]      ddot_x7,
    output logic [31:0]      ddot_y0,
    output logic [31:0]      ddot_y1,
    output logic [31:0]      ddot_y2,
    output logic [31:0]      ddot_y3,
    output logic [31:0]      ddot_y4,
    output logic [31:0]      ddot_y5,
    output logic [31:0]      ddot_y6,
    output logic [31:0]      ddot_y7,
    output logic             ddot_ready,
    input  logic             ddot_vld,
    input  logic [31:0]      ddot_z,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, RESULT} state_t;
    state_t state, state_n;
    logic [3:0] idx;
    logic [31:0] xr [8];
    logic [31:0] yr [8];
    logic [TW-1:0] tcnt;
    logic accept, timeout;
    assign in_ready = state == LOAD;
    assign busy     = state != LOAD;
    assign accept   = in_valid & in_ready;
    assign timeout  = state == WAIT && !ddot_vld && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = (accept && idx == 4'd15) ? ISSUE : LOAD;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = ddot_vld ? RESULT : (timeout ? LOAD : WAIT);
            RESULT:  state_n = res_ready ? LOAD : RESULT;
            default: state_n = LOAD;
        endcase
    end
    // ddot_ready is a flop loaded from the next state so it is high exactly while in ISSUE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= '0;
            tcnt       <= '0;
            ddot_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            err        <= 1'b0;
            done_cnt   <= '0;
            for (int i = 0; i < 8; i++) begin
                xr[i] <= '0;
                yr[i] <= '0;
            end
        end else begin
            ddot_ready <= state_n == ISSUE;
            if (accept) begin
                if (idx[3]) yr[idx[2:0]] <= in_data;
                else        xr[idx[2:0]] <= in_data;
                idx <= idx + 4'd1;
            end
            if (state == ISSUE)                tcnt <= '0;
            else if (state == WAIT && !ddot_vld) tcnt <= tcnt + 1'b1;
            if (state == WAIT && ddot_vld) begin
                res_data  <= ddot_z;
                res_valid <= 1'b1;
            end
            if (state == RESULT && res_ready) begin
                res_valid <= 1'b0;
                done_cnt  <= done_cnt + 1'b1;
            end
            if (timeout) err <= 1'b1;
        end
    end
    assign ddot_x0 = xr[0];
    assign ddot_x1 = xr[1];
    assign ddot_x2 = xr[2];
    assign ddot_x3 = xr[3];
    assign ddot_x4 = xr[4];
    assign ddot_x5 = xr[5];
    assign ddot_x6 = xr[6];
    assign ddot_x7 = xr[7];
    assign ddot_y0 = yr[0];
    assign ddot_y1 = yr[1];
    assign ddot_y2 = yr[2];
    assign ddot_y3 = yr[3];
    assign ddot_y4 = yr[4];
    assign ddot_y5 = yr[5];
    assign ddot_y6 = yr[6];
    assign ddot_y7 = yr[7];
endmodule

// File: tb/tb_ddot_feeder.sv
// tb_ddot_feeder: directed bench for ddot_feeder with a behavioural dot-product unit
// and a result scoreboard checked by an independent monitor.
module tb_ddot_feeder;
    logic clk = 0, rst = 0, in_valid = 0, res_ready = 0;
    logic [31:0] in_data = 0;
    logic in_ready, ddot_ready, ddot_vld, res_valid, busy, err;
    logic [31:0] ddot_z, res_data;
    logic [15:0] done_cnt;
    logic [31:0] x0, x1, x2, x3, x4, x5, x6, x7, y0, y1, y2, y3, y4, y5, y6, y7;
    logic [31:0] ops [16];
    logic model_on = 1, model_vld = 0, stray_vld = 0;
    logic [31:0] model_z = 0;
    logic [31:0] exp_q [$];
    logic [31:0] w [16];
    int total = 0, bad = 0;

    ddot_feeder #(.TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ddot_x0(x0), .ddot_x1(x1), .ddot_x2(x2), .ddot_x3(x3),
        .ddot_x4(x4), .ddot_x5(x5), .ddot_x6(x6), .ddot_x7(x7),
        .ddot_y0(y0), .ddot_y1(y1), .ddot_y2(y2), .ddot_y3(y3),
        .ddot_y4(y4), .ddot_y5(y5), .ddot_y6(y6), .ddot_y7(y7),
        .ddot_ready(ddot_ready), .ddot_vld(ddot_vld), .ddot_z(ddot_z),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err), .done_cnt(done_cnt)
    );

    assign ops = '{x0, x1, x2, x3, x4, x5, x6, x7, y0, y1, y2, y3, y4, y5, y6, y7};
    assign ddot_vld = model_vld | stray_vld;
    assign ddot_z = stray_vld ? 32'hDEADBEEF : (model_vld ? model_z : 32'h0BAD0BAD);

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ops(input string name, input logic [31:0] e [16]);
        for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", name, i), ops[i], e[i]);
    endtask

    // dot-product unit model: vld in the fourth cycle after the ready pulse
    initial forever begin
        @(negedge clk);
        if (ddot_ready && model_on) begin
            repeat (4) @(negedge clk);
            model_vld = 1;
            @(negedge clk);
            model_vld = 0;
        end
    end

    // scoreboard monitor: every delivered result must match the oldest expectation
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", res_data, 32'hxxxxxxxx);
            else chk("res_data", res_data, exp_q.pop_front());
        end
    end

    task automatic load(input logic [31:0] d [16], input bit gaps);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 0;
                @(negedge clk);
                if (i == 15) chk("no_issue_before_16th", {ddot_ready, in_ready}, 2'b01);
                @(posedge clk); #1;
            end
            in_valid = 1;
            in_data = d[i];
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic check_issue();
        @(negedge clk);
        chk("ddot_ready_issue", {ddot_ready, busy, in_ready}, 3'b110);
    endtask

    task automatic wait_result(input int hold, input int exp_lat);
        int n = 0;
        logic [31:0] d;
        logic [15:0] c;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("ddot_ready_one_cycle", ddot_ready, 0);
        end while (!res_valid && n < 40);
        chk("res_valid_rise", res_valid, 1);
        chk("result_latency", n, exp_lat);
        d = res_data;
        c = done_cnt;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_flags", {res_valid, in_ready, busy}, 3'b101);
            chk("hold_data", res_data, d);
            chk("hold_done_cnt", done_cnt, c);
        end
        @(posedge clk); #1 res_ready = 1;
        @(posedge clk); #1 res_ready = 0;
        @(negedge clk);
        chk("done_cnt_inc", done_cnt, c + 16'd1);
        chk("after_accept", {res_valid, in_ready}, 2'b01);
    endtask

    task automatic reset_checks(input string name);
        logic [31:0] z [16];
        for (int i = 0; i < 16; i++) z[i] = 0;
        chk({name, "_flags"}, {in_ready, ddot_ready, res_valid, err, busy}, 5'b10000);
        chk({name, "_done_cnt"}, done_cnt, 0);
        chk({name, "_res_data"}, res_data, 0);
        chk_ops({name, "_ops"}, z);
    endtask

    initial begin
        logic [31:0] last_y7;
        // power-on reset
        #12;
        reset_checks("por");
        @(negedge clk) rst = 1;

        // basic transaction: 8 x 1.0 and 8 x 2.0
        for (int i = 0; i < 16; i++) w[i] = i < 8 ? 32'h3F800000 : 32'h40000000;
        model_z = 32'h41800000;
        exp_q.push_back(32'h41800000);
        load(w, 0);
        check_issue();
        chk_ops("basic_ops", w);
        wait_result(0, 5);
        chk("basic_done_cnt", done_cnt, 1);

        // gapped stream 1..16 with a result held off for 10 cycles
        for (int i = 0; i < 16; i++) w[i] = i + 1;
        model_z = 32'h12345678;
        exp_q.push_back(32'h12345678);
        load(w, 1);
        check_issue();
        chk_ops("gap_ops", w);
        wait_result(10, 5);
        chk("gap_done_cnt", done_cnt, 2);

        // stray vld while loading must be ignored
        @(posedge clk); #1 stray_vld = 1;
        repeat (3) @(posedge clk);
        #1 stray_vld = 0;
        @(negedge clk);
        chk("stray_flags", {in_ready, busy, res_valid}, 3'b100);
        chk("stray_res_data", res_data, 32'h12345678);
        chk("stray_done_cnt", done_cnt, 2);

        // timeout: unit never answers
        model_on = 0;
        for (int i = 0; i < 16; i++) w[i] = 32'hA000_0000 + i;
        load(w, 0);
        check_issue();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) chk("timeout_not_early", {err, in_ready}, 2'b00);
        end
        @(negedge clk);
        chk("timeout_flags", {err, in_ready, res_valid, busy}, 4'b1100);
        chk("timeout_done_cnt", done_cnt, 2);
        chk_ops("timeout_ops_kept", w);
        last_y7 = w[15];

        // good transaction after timeout keeps err
        model_on = 1;
        for (int i = 0; i < 16; i++) w[i] = 32'h4040_0000 ^ (i << 4);
        model_z = 32'hC0A00000;
        exp_q.push_back(32'hC0A00000);
        load(w, 0);
        chk("y7_overwritten", y7, w[15]);
        chk("y7_changed", (y7 != last_y7) ? 32'd1 : 32'd0, 1);
        check_issue();
        wait_result(3, 5);
        chk("post_timeout_err", err, 1);
        chk("post_timeout_done_cnt", done_cnt, 3);

        // reset two cycles into WAIT
        model_on = 0;
        load(w, 0);
        check_issue();
        @(posedge clk);
        @(posedge clk); #1 rst = 0;
        #1 reset_checks("wait_rst");
        @(negedge clk) rst = 1;
        repeat (8) @(negedge clk);
        chk("wait_rst_no_result", {res_valid, in_ready}, 2'b01);

        // reset in the middle of the operand stream
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data = 32'h5555_0000 + i;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("partial_x4", x4, 32'h5555_0004);
        rst = 0;
        #1 reset_checks("stream_rst");
        @(negedge clk) rst = 1;

        // a fresh transaction starts from index 0
        model_on = 1;
        for (int i = 0; i < 16; i++) w[i] = 32'h3F00_0000 + i;
        model_z = 32'h44000000;
        exp_q.push_back(32'h44000000);
        load(w, 0);
        check_issue();
        chk_ops("fresh_ops", w);
        wait_result(0, 5);
        chk("fresh_done_cnt", done_cnt, 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
